// File: rtl/am_lock_fsm_pkg.sv
// Shared PCS constants for 40G/100G alignment-marker lock: AM table, FSM
// encodings and the AM sync header.
package am_lock_fsm_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_INIT     = 3'd0;
    localparam fsm_state_t ST_FIND_1ST = 3'd1;
    localparam fsm_state_t ST_COUNT_1  = 3'd2;
    localparam fsm_state_t ST_COMP_2ND = 3'd3;
    localparam fsm_state_t ST_LOCKED   = 3'd4;

    localparam logic [1:0] AM_SYNC_HDR = 2'b10;
    localparam int         AM_N_ENTRY  = 20;

    // {M0,M1,M2} for each PCS lane (IEEE 802.3 Table 82-2)
    function automatic logic [23:0] am_pattern(input int k);
        case (k)
            0:       return 24'hC1_68_21;
            1:       return 24'h9D_71_8E;
            2:       return 24'h59_4B_E8;
            3:       return 24'h4D_95_7B;
            4:       return 24'hF5_07_09;
            5:       return 24'hDD_14_C2;
            6:       return 24'h9A_4A_26;
            7:       return 24'h7B_45_66;
            8:       return 24'hA0_24_76;
            9:       return 24'h68_C9_FB;
            10:      return 24'hFD_6C_99;
            11:      return 24'hB9_91_55;
            12:      return 24'h5C_B9_B2;
            13:      return 24'h1A_F8_BD;
            14:      return 24'h83_C7_CA;
            15:      return 24'h35_36_CD;
            16:      return 24'hC4_31_4C;
            17:      return 24'hAD_D6_B7;
            18:      return 24'h5F_66_2A;
            19:      return 24'hC0_F0_E5;
            default: return 24'h00_00_00;
        endcase
    endfunction

endpackage

// File: rtl/am_lock_fsm_if.sv
// Lane-block stream into the AM lock FSM and its lock/flag results.
interface am_lock_if #(
    parameter int NB_DATA_CODED = 66,
    parameter int NB_LANE_ID    = 5
);
    logic                     i_enable;
    logic                     i_valid;
    logic                     i_block_lock;
    logic [NB_DATA_CODED-1:0] i_data;
    logic [NB_DATA_CODED-1:0] o_data;
    logic                     o_valid;
    logic                     o_am_flag;
    logic                     o_am_lock;
    logic [NB_LANE_ID-1:0]    o_lane_id;
    logic                     o_resync;

    modport master (
        output i_enable, i_valid, i_block_lock, i_data,
        input  o_data, o_valid, o_am_flag, o_am_lock, o_lane_id, o_resync
    );

    modport slave (
        input  i_enable, i_valid, i_block_lock, i_data,
        output o_data, o_valid, o_am_flag, o_am_lock, o_lane_id, o_resync
    );
endinterface

// File: rtl/am_pattern_matcher.sv
// Combinational AM detector: compares one block against every lane pattern
// (BIP bytes are not part of the inputs). Lowest matching index wins.
module am_pattern_matcher
    import am_lock_fsm_pkg::*;
#(
    parameter int N_LANES = 20,
    parameter int NB_IDX  = 5
) (
    input  logic [1:0]        i_sync,
    input  logic [23:0]       i_m012,
    input  logic [23:0]       i_m456,
    output logic              o_match,
    output logic [NB_IDX-1:0] o_idx
);

    always_comb begin
        o_match = 1'b0;
        o_idx   = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (i_sync == AM_SYNC_HDR && i_m012 == am_pattern(k) &&
                i_m456 == ~am_pattern(k)) begin
                o_match = 1'b1;
                o_idx   = NB_IDX'(k);
            end
        end
    end

endmodule

// File: rtl/am_lock_fsm.sv
// Per-lane alignment-marker lock FSM: finds an AM, confirms it one period
// later, then tracks every expected AM position and drops lock on repeated misses.
//
// state    | meaning
// INIT     | no block lock; lock and counters cleared
// FIND_1ST | searching every valid block for any lane AM
// COUNT_1  | counting data blocks toward the confirming AM
// COMP_2ND | next valid block must be the captured lane's AM
// LOCKED   | AM lock held; checking each expected AM position
module am_lock_fsm
    import am_lock_fsm_pkg::*;
#(
    parameter int NB_DATA_CODED   = 66,
    parameter int N_LANES         = 20,
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int MAX_INV_AM      = 4,
    parameter int NB_LANE_ID      = 5
) (
    input  logic    i_clock,
    input  logic    i_reset,
    am_lock_if.slave bus
);

    localparam int CNT_W = $clog2(AM_BLOCK_PERIOD + 1);
    localparam int INV_W = $clog2(MAX_INV_AM + 1);
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(AM_BLOCK_PERIOD);
    localparam logic [INV_W-1:0] MAX_INV_C = INV_W'(MAX_INV_AM);

    fsm_state_t               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [INV_W-1:0]         r_inv;
    logic [NB_LANE_ID-1:0]    r_lane_cap;
    logic [NB_DATA_CODED-1:0] r_o_data;
    logic                     r_o_valid;
    logic                     r_am_flag;
    logic                     r_am_lock;
    logic [NB_LANE_ID-1:0]    r_lane_id;
    logic                     r_resync;

    logic                     w_match;
    logic [NB_LANE_ID-1:0]    w_idx;
    logic                     w_exp_am;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic [INV_W-1:0]         w_inv_inc;

    am_pattern_matcher #(
        .N_LANES (N_LANES),
        .NB_IDX  (NB_LANE_ID)
    ) u_matcher (
        .i_sync  (bus.i_data[65:64]),
        .i_m012  (bus.i_data[63:40]),
        .i_m456  (bus.i_data[31:8]),
        .o_match (w_match),
        .o_idx   (w_idx)
    );

    assign w_exp_am  = w_match && (w_idx == r_lane_cap);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_inv_inc = r_inv + 1'b1;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_inv      <= '0;
            r_lane_cap <= '0;
            r_o_data   <= '0;
            r_o_valid  <= 1'b0;
            r_am_flag  <= 1'b0;
            r_am_lock  <= 1'b0;
            r_lane_id  <= '0;
            r_resync   <= 1'b0;
        end else begin
            r_o_data  <= bus.i_data;
            r_o_valid <= bus.i_valid & bus.i_enable;
            r_am_flag <= 1'b0;
            r_resync  <= 1'b0;
            // Loss of block lock acts on any enabled cycle, valid or not, and
            // outranks whatever the current block would have decided.
            if (bus.i_enable && !bus.i_block_lock) begin
                r_resync  <= (r_state == ST_LOCKED);
                r_state   <= ST_INIT;
                r_cnt     <= '0;
                r_inv     <= '0;
                r_am_lock <= 1'b0;
                r_lane_id <= '0;
            end else if (bus.i_enable && bus.i_valid) begin
                case (r_state)
                    ST_INIT: begin
                        r_state <= ST_FIND_1ST;
                        r_cnt   <= '0;
                        r_inv   <= '0;
                    end
                    ST_FIND_1ST: begin
                        if (w_match) begin
                            r_lane_cap <= w_idx;
                            r_cnt      <= '0;
                            r_state    <= ST_COUNT_1;
                        end
                    end
                    ST_COUNT_1: begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == PERIOD_C) begin
                            r_state <= ST_COMP_2ND;
                        end
                    end
                    ST_COMP_2ND: begin
                        r_cnt <= '0;
                        if (w_exp_am) begin
                            r_state   <= ST_LOCKED;
                            r_am_lock <= 1'b1;
                            r_lane_id <= r_lane_cap;
                            r_inv     <= '0;
                        end else begin
                            r_state <= ST_FIND_1ST;
                        end
                    end
                    ST_LOCKED: begin
                        if (r_cnt == PERIOD_C) begin
                            r_cnt <= '0;
                            if (w_exp_am) begin
                                r_inv     <= '0;
                                r_am_flag <= 1'b1;
                            end else if (w_inv_inc == MAX_INV_C) begin
                                r_inv     <= '0;
                                r_am_lock <= 1'b0;
                                r_lane_id <= '0;
                                r_resync  <= 1'b1;
                                r_state   <= ST_FIND_1ST;
                            end else begin
                                r_inv <= w_inv_inc;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_INIT;
                    end
                endcase
            end
        end
    end

    assign bus.o_data    = r_o_data;
    assign bus.o_valid   = r_o_valid;
    assign bus.o_am_flag = r_am_flag;
    assign bus.o_am_lock = r_am_lock;
    assign bus.o_lane_id = r_lane_id;
    assign bus.o_resync  = r_resync;

endmodule

// File: tb/tb_am_lock_fsm.sv
// Directed bench for am_lock_fsm with a 100-block AM period.
module tb_am_lock_fsm;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    am_lock_if #(.NB_DATA_CODED(66), .NB_LANE_ID(5)) bus();

    am_lock_fsm #(
        .NB_DATA_CODED   (66),
        .N_LANES         (20),
        .AM_BLOCK_PERIOD (100),
        .MAX_INV_AM      (4),
        .NB_LANE_ID      (5)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [23:0] pat(input int k);
        case (k)
            2:       return 24'h59_4B_E8;
            3:       return 24'h4D_95_7B;
            5:       return 24'hDD_14_C2;
            6:       return 24'h9A_4A_26;
            default: return 24'h00_00_00;
        endcase
    endfunction

    function automatic logic [65:0] am_blk(input int k);
        logic [23:0] m;
        m = pat(k);
        return {2'b10, m, 8'h3C, ~m, 8'hC3};
    endfunction

    function automatic logic [65:0] bad_blk(input int k);
        logic [23:0] m;
        m = pat(k);
        return {2'b10, m, 8'h3C, ~m ^ 24'h00_01_00, 8'hC3};
    endfunction

    function automatic logic [65:0] data_blk(input int i);
        return {2'b01, 32'(32'hD00D_0000 + i), 32'(32'h1234_5678 ^ i)};
    endfunction

    task automatic step(input logic v, input logic [65:0] d);
        bus.i_valid = v;
        bus.i_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_data(input int n);
        for (int i = 0; i < n; i++) step(1'b1, data_blk(i));
    endtask

    task automatic acquire(input int k);
        step(1'b1, data_blk(999));
        step(1'b1, am_blk(k));
        run_data(100);
        step(1'b1, am_blk(k));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1'b1, am_blk(3));
        step(1'b1, am_blk(3));
        total++; if (bus.o_data !== 66'h0) begin bad++; $display("FAIL rst_data got=%0h want=0", bus.o_data); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.o_valid); end
        total++; if (bus.o_am_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%0b want=0", bus.o_am_flag); end
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL rst_lock got=%0b want=0", bus.o_am_lock); end
        total++; if (bus.o_lane_id !== 5'd0) begin bad++; $display("FAIL rst_lane got=%0d want=0", bus.o_lane_id); end
        total++; if (bus.o_resync !== 1'b0) begin bad++; $display("FAIL rst_resync got=%0b want=0", bus.o_resync); end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        step(1'b1, data_blk(7));
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL lk_valid got=%0b want=1", bus.o_valid); end
        total++; if (bus.o_data !== data_blk(7)) begin bad++; $display("FAIL lk_data got=%0h want=%0h", bus.o_data, data_blk(7)); end
        step(1'b1, am_blk(3));
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL lk_first got=%0b want=0", bus.o_am_lock); end
        run_data(100);
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL lk_count got=%0b want=0", bus.o_am_lock); end
        step(1'b1, am_blk(3));
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL lk_lock got=%0b want=1", bus.o_am_lock); end
        total++; if (bus.o_lane_id !== 5'd3) begin bad++; $display("FAIL lk_lane got=%0d want=3", bus.o_lane_id); end
        total++; if (bus.o_data !== am_blk(3)) begin bad++; $display("FAIL lk_amdata got=%0h want=%0h", bus.o_data, am_blk(3)); end
    endtask

    task automatic test_second_wrong();
        rst = 1'b0;
        step(1'b0, 66'h0);
        rst = 1'b1;
        step(1'b1, data_blk(1));
        step(1'b1, am_blk(5));
        run_data(100);
        step(1'b1, am_blk(6));
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL sw_nolock got=%0b want=0", bus.o_am_lock); end
        run_data(100);
        step(1'b1, am_blk(6));
        run_data(100);
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL sw_pending got=%0b want=0", bus.o_am_lock); end
        step(1'b1, am_blk(6));
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL sw_lock got=%0b want=1", bus.o_am_lock); end
        total++; if (bus.o_lane_id !== 5'd6) begin bad++; $display("FAIL sw_lane got=%0d want=6", bus.o_lane_id); end
    endtask

    task automatic test_loss();
        for (int j = 0; j < 3; j++) begin
            run_data(100);
            step(1'b1, bad_blk(6));
            total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL ls_hold%0d got=%0b want=1", j, bus.o_am_lock); end
            total++; if (bus.o_am_flag !== 1'b0) begin bad++; $display("FAIL ls_badflag%0d got=%0b want=0", j, bus.o_am_flag); end
        end
        run_data(100);
        step(1'b1, am_blk(6));
        total++; if (bus.o_am_flag !== 1'b1) begin bad++; $display("FAIL ls_goodflag got=%0b want=1", bus.o_am_flag); end
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL ls_goodlock got=%0b want=1", bus.o_am_lock); end
        for (int j = 0; j < 4; j++) begin
            run_data(100);
            step(1'b1, bad_blk(6));
            if (j < 3) begin
                total++; if (bus.o_am_lock !== 1'b1 || bus.o_resync !== 1'b0) begin bad++; $display("FAIL ls_miss%0d lock=%0b resync=%0b want lock=1 resync=0", j, bus.o_am_lock, bus.o_resync); end
            end else begin
                total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL ls_drop got=%0b want=0", bus.o_am_lock); end
                total++; if (bus.o_resync !== 1'b1) begin bad++; $display("FAIL ls_resync got=%0b want=1", bus.o_resync); end
            end
        end
        step(1'b1, data_blk(3));
        total++; if (bus.o_resync !== 1'b0) begin bad++; $display("FAIL ls_pulse got=%0b want=0", bus.o_resync); end
        total++; if (bus.o_lane_id !== 5'd0) begin bad++; $display("FAIL ls_lane got=%0d want=0", bus.o_lane_id); end
    endtask

    task automatic test_gaps();
        acquire(6);
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL gp_lock got=%0b want=1", bus.o_am_lock); end
        for (int i = 0; i < 100; i++) begin
            step(1'b0, am_blk(6));
            if (i == 50) begin
                bus.i_enable = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    step(1'b1, am_blk(6));
                    total++; if (bus.o_valid !== 1'b0 || bus.o_am_flag !== 1'b0) begin bad++; $display("FAIL gp_dis%0d valid=%0b flag=%0b want 0 0", c, bus.o_valid, bus.o_am_flag); end
                end
                bus.i_enable = 1'b1;
            end
            step(1'b1, (i == 30) ? am_blk(6) : data_blk(i));
            total++; if (bus.o_am_flag !== 1'b0) begin bad++; $display("FAIL gp_flag%0d got=%0b want=0", i, bus.o_am_flag); end
        end
        step(1'b0, data_blk(0));
        step(1'b1, am_blk(6));
        total++; if (bus.o_am_flag !== 1'b1) begin bad++; $display("FAIL gp_amflag got=%0b want=1", bus.o_am_flag); end
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL gp_held got=%0b want=1", bus.o_am_lock); end
        run_data(100);
        step(1'b1, am_blk(6));
        total++; if (bus.o_am_flag !== 1'b1) begin bad++; $display("FAIL gp_amflag2 got=%0b want=1", bus.o_am_flag); end
    endtask

    task automatic test_reset_mid();
        bus.i_enable = 1'b0;
        rst = 1'b0;
        step(1'b1, am_blk(6));
        total++; if (bus.o_data !== 66'h0) begin bad++; $display("FAIL rm_data got=%0h want=0", bus.o_data); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", bus.o_valid); end
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL rm_lock got=%0b want=0", bus.o_am_lock); end
        total++; if (bus.o_lane_id !== 5'd0) begin bad++; $display("FAIL rm_lane got=%0d want=0", bus.o_lane_id); end
        total++; if (bus.o_resync !== 1'b0) begin bad++; $display("FAIL rm_resync got=%0b want=0", bus.o_resync); end
        total++; if (bus.o_am_flag !== 1'b0) begin bad++; $display("FAIL rm_flag got=%0b want=0", bus.o_am_flag); end
        rst = 1'b1;
        bus.i_enable = 1'b1;
    endtask

    task automatic test_block_lock_drop();
        acquire(2);
        total++; if (bus.o_am_lock !== 1'b1 || bus.o_lane_id !== 5'd2) begin bad++; $display("FAIL bl_lock lock=%0b lane=%0d want 1 2", bus.o_am_lock, bus.o_lane_id); end
        run_data(20);
        bus.i_block_lock = 1'b0;
        step(1'b1, data_blk(21));
        total++; if (bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL bl_drop got=%0b want=0", bus.o_am_lock); end
        total++; if (bus.o_lane_id !== 5'd0) begin bad++; $display("FAIL bl_lane got=%0d want=0", bus.o_lane_id); end
        total++; if (bus.o_resync !== 1'b1) begin bad++; $display("FAIL bl_resync got=%0b want=1", bus.o_resync); end
        step(1'b1, data_blk(22));
        total++; if (bus.o_resync !== 1'b0) begin bad++; $display("FAIL bl_pulse got=%0b want=0", bus.o_resync); end
        bus.i_block_lock = 1'b1;
        acquire(2);
        for (int j = 0; j < 3; j++) begin
            run_data(100);
            step(1'b1, bad_blk(2));
        end
        total++; if (bus.o_am_lock !== 1'b1) begin bad++; $display("FAIL bl_relock got=%0b want=1", bus.o_am_lock); end
        run_data(100);
        bus.i_block_lock = 1'b0;
        step(1'b1, bad_blk(2));
        total++; if (bus.o_resync !== 1'b1 || bus.o_am_lock !== 1'b0) begin bad++; $display("FAIL bl_coinc resync=%0b lock=%0b want 1 0", bus.o_resync, bus.o_am_lock); end
        step(1'b1, data_blk(5));
        total++; if (bus.o_resync !== 1'b0) begin bad++; $display("FAIL bl_single got=%0b want=0", bus.o_resync); end
        bus.i_block_lock = 1'b1;
    endtask

    initial begin
        rst              = 1'b0;
        bus.i_enable     = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_block_lock = 1'b1;
        bus.i_data       = '0;
        test_reset();
        test_lock();
        test_second_wrong();
        test_loss();
        test_gaps();
        test_reset_mid();
        test_block_lock_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/am_lock_fsm.md
AM_LOCK_FSM -- requirements
Module: am_lock_fsm

Interface
REQ-001 Parameter NB_DATA_CODED, default 66: width of one coded 64b/66b block.
REQ-002 Parameter N_LANES, default 20: number of PCS lanes and alignment-marker (AM) patterns.
REQ-003 Parameter AM_BLOCK_PERIOD, default 16383: number of data blocks between consecutive AMs on one lane.
REQ-004 Parameter MAX_INV_AM, default 4: number of consecutive bad AMs that causes loss of lock.
REQ-005 Parameter NB_LANE_ID, default 5: width of the lane-number output.
REQ-006 Port i_clock, input, 1: the single clock; all state changes occur on its rising edge.
REQ-007 Port i_reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-008 Port i_enable, input, 1: block enable from the register file.
REQ-009 Port i_valid, input, 1: marks i_data as a new lane block this cycle.
REQ-010 Port i_block_lock, input, 1: 66b sync-header lock for this lane.
REQ-011 Port i_data, input, NB_DATA_CODED: one received lane block; [65:64] sync header, [63:0] = {M0,M1,M2,BIP3,M4,M5,M6,BIP7}.
REQ-012 Port o_data, output, NB_DATA_CODED: i_data delayed by 1 cycle.
REQ-013 Port o_valid, output, 1: i_valid & i_enable delayed by 1 cycle.
REQ-014 Port o_am_flag, output, 1: aligned with o_data; high when the block is the expected AM while locked.
REQ-015 Port o_am_lock, output, 1: lane AM lock status.
REQ-016 Port o_lane_id, output, NB_LANE_ID: physical-to-logical lane number captured from the AM.
REQ-017 Port o_resync, output, 1: one-cycle pulse on loss of lock.

Function
REQ-018 A block SHALL match pattern k when [65:64]=2'b10, {M0,M1,M2} equals AM table entry k, and {M4,M5,M6} equals its bitwise complement; BIP bytes are ignored.
REQ-019 Only cycles with i_valid=1 and i_enable=1 SHALL advance the FSM or the counters; with i_enable=0 all state holds and o_valid=0.
REQ-020 FSM states SHALL be INIT, FIND_1ST, COUNT_1, COMP_2ND, LOCKED.
REQ-021 INIT behaviour: o_am_lock=0 and counters clear; go to FIND_1ST when i_block_lock=1.
REQ-022 FIND_1ST behaviour: each valid block is compared against all N_LANES entries.
REQ-023 FIND_1ST transition: on a match, capture the lane index k, clear the block counter, and go to COUNT_1.
REQ-024 COUNT_1 SHALL count valid blocks and enter COMP_2ND when the counter reaches AM_BLOCK_PERIOD, so the next valid block is the expected AM.
REQ-025 COMP_2ND, match of the captured k: go to LOCKED with o_am_lock=1, o_lane_id=k, invalid counter=0.
REQ-026 COMP_2ND, any other block: go back to FIND_1ST.
REQ-027 LOCKED SHALL count valid blocks the same way and evaluate every expected AM position.
REQ-028 LOCKED, good AM: clear the invalid counter and raise o_am_flag for that block.
REQ-029 LOCKED, bad AM: increment the invalid counter; o_am_flag stays low.
REQ-030 When the invalid counter reaches MAX_INV_AM, the FSM SHALL clear o_am_lock, pulse o_resync, and go to FIND_1ST.
REQ-031 The block counter SHALL be ceil(log2(AM_BLOCK_PERIOD+1)) bits wide, restart at 0 after each expected AM position, and never wrap otherwise.
REQ-032 i_block_lock=0 in any state SHALL force INIT on the next edge.
REQ-033 If i_block_lock drops while locked, o_resync SHALL pulse.
REQ-034 If i_block_lock drop and a bad AM coincide, INIT SHALL win and only one o_resync pulse SHALL be issued.
REQ-035 A pattern match outside an expected AM position while LOCKED SHALL be ignored.
REQ-036 o_am_lock, o_lane_id and o_resync SHALL be registered and take effect in the cycle after the deciding block.

Reset
REQ-037 On i_reset=0 at a clock edge: FSM=INIT, all counters 0, o_data=0, o_valid=0, o_am_flag=0, o_am_lock=0, o_lane_id=0, o_resync=0.
REQ-038 Reset asserted mid-operation SHALL take priority over every other event, including i_enable.

Structure
REQ-039 A shared PCS package SHALL hold the 20-entry AM table (IEEE 802.3 Table 82-2; lane0 C1_68_21, lane1 9D_71_8E, ... lane19 C0_F0_E5), the FSM state encodings, and the AM sync-header constant.
REQ-040 One sub-module, am_pattern_matcher, SHALL hold the combinational comparison: a block in, a match flag plus matched index out.
REQ-041 The RX toplevel SHALL instantiate am_lock_fsm N_LANES times.

Verification
REQ-042 Run with AM_BLOCK_PERIOD=100.
REQ-043 Lock: block_lock=1, lane-3 AM (4D_95_7B/complement), 100 data blocks, lane-3 AM -> o_am_lock=1 and o_lane_id=3 in the cycle after the second AM.
REQ-044 Second AM wrong: first AM lane 5, second AM lane 6 -> no lock; a lane-6 AM 101 blocks later followed by a second lane-6 AM then locks with o_lane_id=6.
REQ-045 Loss: locked, then 3 corrupted AMs and 1 good AM -> stays locked; then 4 consecutive corrupted AMs -> o_resync pulse and o_am_lock=0 one cycle after the 4th.
REQ-046 Gaps: i_valid toggling 50% and i_enable low for 10 cycles while locked -> lock held and o_am_flag only on true AMs.
REQ-047 Reset/block_lock: i_reset=0 for 1 cycle or i_block_lock=0 while locked -> all outputs per REQ-037 on the next edge (o_resync pulses only for the block_lock case).
